// File: rtl/l2_types_pkg.sv
// ---------------------------------------------------------------------------
// l2_types_pkg
// Shared types and constants for the L2 cache controller.
//   l2_state_e        controller states
//   way_t             one-bit way index of the 2-way cache
//   PMEM_ADDR_*       encodings of the pmem_addr_sel output
//   DATA_IN_*         encodings of the data_in_sel output
//   victim_is_dirty() dirty bit of the way that LRU would evict
// ---------------------------------------------------------------------------
package l2_types_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } l2_state_e;

    typedef logic way_t;

    localparam logic PMEM_ADDR_REQ    = 1'b0;
    localparam logic PMEM_ADDR_VICTIM = 1'b1;

    localparam logic DATA_IN_PMEM = 1'b0;
    localparam logic DATA_IN_MDR  = 1'b1;

    function automatic logic victim_is_dirty(input way_t lru_way, input logic d0, input logic d1);
        return (lru_way == 1'b1) ? d1 : d0;
    endfunction

endpackage

// File: rtl/l2_cache_control_checker.sv
// ---------------------------------------------------------------------------
// l2_cache_control_checker
// Simulation-time property checks for l2_cache_control.
//   clk, rst   clock and asynchronous active-high reset
//   in_check   controller is in its tag-compare state
//   request    arbiter request present (read or write)
//   hit0/hit1  datapath way-match flags
// ---------------------------------------------------------------------------
module l2_cache_control_checker #(
    parameter int CNT_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    input logic in_check,
    input logic request,
    input logic hit0,
    input logic hit1
);

    // Both ways matching one address means the tag/valid arrays are corrupt.
    a_single_way_hit: assert property (@(posedge clk) disable iff (rst)
        (in_check && request) |-> !(hit0 && hit1));

    // A zero-width performance counter is meaningless.
    a_cnt_width: assert property (@(posedge clk) disable iff (rst) CNT_WIDTH > 0);

endmodule

// File: rtl/l2_perf_counter.sv
// ---------------------------------------------------------------------------
// l2_perf_counter
// Single saturating event counter; sticks at all-ones instead of wrapping.
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset (clears the count)
//   inc    in   count one event this cycle
//   count  out  current count [CNT_WIDTH-1:0]
// ---------------------------------------------------------------------------
module l2_perf_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Next count: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/l2_cache_control.sv
// ---------------------------------------------------------------------------
// l2_cache_control
// Control FSM of the 2-way set-associative unified L2 cache. Hits complete in
// one CHECK cycle; misses optionally write back a dirty victim, then allocate
// the line from physical memory and re-check.
//
// Optional feature macro: L2_PERF_CNT_EN adds saturating hit/miss counters
// (hit_count, miss_count, CNT_WIDTH bits). Without it those ports are absent.
//
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   l2_read, l2_write            arbiter request, held until l2_resp
//   l2_resp                      one-cycle completion pulse
//   hit0, hit1                   datapath way match for current address
//   dirty0, dirty1, lru          per-set state of the indexed set
//   pmem_resp                    physical memory done
//   pmem_read, pmem_write        physical memory line transfer
//   pmem_addr_sel                0 request address, 1 victim address
//   data_in_sel                  0 line from pmem, 1 merged line from MDR
//   way_sel                      way addressed by the load strobes
//   load_data/tag/valid/dirty    array write strobes, dirty_in is dirty value
//   load_lru, lru_in             LRU update strobe and new LRU value
//   hit_count, miss_count        (L2_PERF_CNT_EN only) event counters
// ---------------------------------------------------------------------------
module l2_cache_control
    import l2_types_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic l2_read,
    input  logic l2_write,
    output logic l2_resp,
    input  logic hit0,
    input  logic hit1,
    input  logic dirty0,
    input  logic dirty1,
    input  logic lru,
    input  logic pmem_resp,
    output logic pmem_read,
    output logic pmem_write,
    output logic pmem_addr_sel,
    output logic data_in_sel,
    output logic way_sel,
    output logic load_data,
    output logic load_tag,
    output logic load_valid,
    output logic load_dirty,
    output logic dirty_in,
    output logic load_lru,
    output logic lru_in
`ifdef L2_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
`endif
);

    l2_state_e state_q;
    l2_state_e state_d;

    logic request_s;
    logic hit_s;
    way_t hit_way_s;

    // A simultaneous read and write is handled as a write.
    assign request_s = l2_read | l2_write;
    assign hit_s     = hit0 | hit1;
    assign hit_way_s = hit1;

    // Next-state and output decode; every strobe defaults to inactive.
    always_comb begin
        state_d       = state_q;
        l2_resp       = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = PMEM_ADDR_REQ;
        data_in_sel   = DATA_IN_PMEM;
        way_sel       = 1'b0;
        load_data     = 1'b0;
        load_tag      = 1'b0;
        load_valid    = 1'b0;
        load_dirty    = 1'b0;
        dirty_in      = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;

        case (state_q)
            IDLE: begin
                if (request_s) begin
                    state_d = CHECK;
                end else begin
                    state_d = IDLE;
                end
            end

            CHECK: begin
                if (!request_s) begin
                    // Arbiter withdrew the request: touch nothing.
                    state_d = IDLE;
                end else if (hit_s) begin
                    l2_resp  = 1'b1;
                    way_sel  = hit_way_s;
                    load_lru = 1'b1;
                    lru_in   = ~hit_way_s;
                    if (l2_write) begin
                        load_data   = 1'b1;
                        data_in_sel = DATA_IN_MDR;
                        load_dirty  = 1'b1;
                        dirty_in    = 1'b1;
                    end else begin
                        load_data   = 1'b0;
                    end
                    state_d = IDLE;
                end else begin
                    way_sel = lru;
                    if (victim_is_dirty(lru, dirty0, dirty1)) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = PMEM_ADDR_VICTIM;
                way_sel       = lru;
                if (pmem_resp) begin
                    state_d = ALLOCATE;
                end else begin
                    state_d = WRITEBACK;
                end
            end

            ALLOCATE: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = PMEM_ADDR_REQ;
                way_sel       = lru;
                if (pmem_resp) begin
                    // Fresh line from memory: valid and clean.
                    load_data   = 1'b1;
                    load_tag    = 1'b1;
                    load_valid  = 1'b1;
                    load_dirty  = 1'b1;
                    dirty_in    = 1'b0;
                    data_in_sel = DATA_IN_PMEM;
                    state_d     = CHECK;
                end else begin
                    state_d = ALLOCATE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any pmem transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef L2_PERF_CNT_EN
    logic recheck_q;
    logic recheck_d;
    logic hit_event_s;
    logic miss_event_s;

    // The CHECK that follows an allocation is a re-check, not a new hit.
    always_comb begin
        recheck_d = (state_q == ALLOCATE) && pmem_resp;
    end

    // Re-check marker register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recheck_q <= 1'b0;
        end else begin
            recheck_q <= recheck_d;
        end
    end

    assign hit_event_s  = (state_q == CHECK) && request_s && hit_s && !recheck_q;
    assign miss_event_s = (state_q == CHECK) && request_s && !hit_s;

    l2_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_event_s),
        .count (hit_count)
    );

    l2_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_event_s),
        .count (miss_count)
    );
`endif

    l2_cache_control_checker #(.CNT_WIDTH(CNT_WIDTH)) u_checker (
        .clk      (clk),
        .rst      (rst),
        .in_check (state_q == CHECK),
        .request  (request_s),
        .hit0     (hit0),
        .hit1     (hit1)
    );

endmodule

// File: tb/tb_l2_cache_control.sv
// ---------------------------------------------------------------------------
// tb_l2_cache_control
// Self-checking bench for l2_cache_control. Each transaction is described by
// its request kind, hit way, victim state and memory latencies; the expected
// per-cycle output trace is built from the controller's documented behaviour
// and compared with the observed trace.
// ---------------------------------------------------------------------------
module tb_l2_cache_control;

    localparam int CW = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic l2_read, l2_write, l2_resp;
    logic hit0, hit1, dirty0, dirty1, lru, pmem_resp;
    logic pmem_read, pmem_write, pmem_addr_sel, data_in_sel, way_sel;
    logic load_data, load_tag, load_valid, load_dirty, dirty_in, load_lru, lru_in;
`ifdef L2_PERF_CNT_EN
    logic [CW-1:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    l2_cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .l2_read(l2_read), .l2_write(l2_write), .l2_resp(l2_resp),
        .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1), .lru(lru),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .data_in_sel(data_in_sel), .way_sel(way_sel),
        .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
        .load_dirty(load_dirty), .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in)
`ifdef L2_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Output bit positions in the observed/expected vectors.
    localparam logic [12:0] O_RESP  = 13'h1000;
    localparam logic [12:0] O_PR    = 13'h0800;
    localparam logic [12:0] O_PW    = 13'h0400;
    localparam logic [12:0] O_ASEL  = 13'h0200;
    localparam logic [12:0] O_DSEL  = 13'h0100;
    localparam logic [12:0] O_WAY   = 13'h0080;
    localparam logic [12:0] O_LD    = 13'h0040;
    localparam logic [12:0] O_LT    = 13'h0020;
    localparam logic [12:0] O_LV    = 13'h0010;
    localparam logic [12:0] O_LDY   = 13'h0008;
    localparam logic [12:0] O_DIN   = 13'h0004;
    localparam logic [12:0] O_LLRU  = 13'h0002;
    localparam logic [12:0] O_LRUIN = 13'h0001;

    logic [12:0] obs;
    assign obs = {l2_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, way_sel,
                  load_data, load_tag, load_valid, load_dirty, dirty_in, load_lru, lru_in};

    int vectors = 0;
    int miscompares = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [12:0] got_q[$];
    logic [12:0] exp_q[$];

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    // Expected outputs of a completing hit on way w.
    function automatic logic [12:0] hit_vec(input logic w, input logic is_wr);
        logic [12:0] v;
        v = O_RESP | O_LLRU | (w ? O_WAY : 13'h0000) | (w ? 13'h0000 : O_LRUIN);
        if (is_wr) v = v | O_LD | O_DSEL | O_LDY | O_DIN;
        return v;
    endfunction

    // One clock of stimulus; records observed and expected outputs.
    task automatic cyc(input logic rd, input logic wr, input logic h0, input logic h1,
                       input logic pr, input logic [12:0] e);
        l2_read = rd; l2_write = wr; hit0 = h0; hit1 = h1; pmem_resp = pr;
        @(negedge clk);
        got_q.push_back(obs);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with stray hit flags and stray pmem_resp; nothing may move.
    task automatic idle(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(2, 0);
            cyc(1'b0, 1'b0, k == 1, k == 2, rb(), 13'h0000);
        end
    endtask

    // One full request. hitw: 0 miss, 1 way0 hit, 2 way1 hit.
    task automatic run_txn(input logic rd, input logic wr, input int hitw, input logic lru_v,
                           input logic d0, input logic d1, input int wb_lat, input int al_lat);
        logic h0, h1;
        logic [12:0] wv;
        lru = lru_v; dirty0 = d0; dirty1 = d1;
        h0 = (hitw == 1); h1 = (hitw == 2);
        wv = lru_v ? O_WAY : 13'h0000;
        cyc(rd, wr, h0, h1, rb(), 13'h0000);
        if (hitw != 0) begin
            cyc(rd, wr, h0, h1, rb(), hit_vec(h1, wr));
            exp_hits = (exp_hits == CNT_MAX) ? CNT_MAX : exp_hits + 1;
        end else begin
            exp_misses = (exp_misses == CNT_MAX) ? CNT_MAX : exp_misses + 1;
            cyc(rd, wr, 1'b0, 1'b0, rb(), wv);
            if (lru_v ? d1 : d0) begin
                for (int i = 0; i < wb_lat; i++)
                    cyc(rd, wr, 1'b0, 1'b0, i == wb_lat - 1, O_PW | O_ASEL | wv);
            end
            for (int i = 0; i < al_lat; i++)
                cyc(rd, wr, 1'b0, 1'b0, i == al_lat - 1,
                    O_PR | wv | ((i == al_lat - 1) ? (O_LD | O_LT | O_LV | O_LDY) : 13'h0000));
            // Re-check: the freshly allocated way now matches.
            cyc(rd, wr, !lru_v, lru_v, rb(), hit_vec(lru_v, wr));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        l2_read = 1'b1; l2_write = 1'b0; hit0 = 1'b1; hit1 = 1'b0;
        dirty0 = 1'b0; dirty1 = 1'b0; lru = 1'b0; pmem_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== 13'h0000) begin
                miscompares++;
                $display("FAIL reset[%0d]: outputs %b, required %b", i, obs, 13'h0000);
            end
        end
        l2_read = 1'b0; hit0 = 1'b0; pmem_resp = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_hit();
        got_q.delete(); exp_q.delete();
        run_txn(1'b1, 1'b0, 2, rb(), rb(), rb(), 1, 1);
        run_txn(1'b1, 1'b0, 1, rb(), rb(), rb(), 1, 1);
        idle(1);
        foreach (got_q[i]) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL read_hit[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_write_hit();
        got_q.delete(); exp_q.delete();
        run_txn(1'b0, 1'b1, 1, rb(), rb(), rb(), 1, 1);
        run_txn(1'b0, 1'b1, 2, rb(), rb(), rb(), 1, 1);
        idle(1);
        foreach (got_q[i]) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL write_hit[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clean_miss();
        int resp_at;
        got_q.delete(); exp_q.delete();
        run_txn(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 3, 5);
        resp_at = -1;
        foreach (got_q[i]) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL clean_miss[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
            end
            if (resp_at < 0 && (got_q[i] & O_RESP) != 13'h0000) resp_at = i;
        end
        vectors++;
        if (resp_at != 7) begin
            miscompares++;
            $display("FAIL clean_miss_latency: l2_resp after %0d cycles, expected 7", resp_at);
        end
        idle(1);
    endtask

    task automatic test_dirty_miss();
        got_q.delete(); exp_q.delete();
        run_txn(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 4, 3);
        // Read and write together behave as a write.
        run_txn(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 2, 2);
        idle(1);
        foreach (got_q[i]) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL dirty_miss[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_dropped();
        got_q.delete(); exp_q.delete();
        lru = 1'b0; dirty0 = 1'b1; dirty1 = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 13'h0000);
        // Must be back in IDLE: a new request waits a cycle before responding.
        run_txn(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1, 1);
        foreach (got_q[i]) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL dropped[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete(); exp_q.delete();
        for (int t = 0; t < 4; t++)
            run_txn(rb(), 1'b1, (t % 2) + 1, rb(), rb(), rb(), 1, 1);
        run_txn(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1, 1);
        run_txn(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1, 1);
        foreach (got_q[i]) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
            end
        end
        idle(1);
    endtask

    task automatic test_random();
        logic rd, wr;
        got_q.delete(); exp_q.delete();
        for (int t = 0; t < 40; t++) begin
            rd = rb(); wr = rb();
            if (!rd && !wr) rd = 1'b1;
            run_txn(rd, wr, $urandom_range(2, 0), rb(), rb(), rb(),
                    $urandom_range(6, 1), $urandom_range(6, 1));
            idle($urandom_range(2, 0));
        end
        foreach (got_q[i]) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL random[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_in_allocate();
        lru = 1'b0; dirty0 = 1'b0; dirty1 = 1'b0;
        l2_read = 1'b1; l2_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0; pmem_resp = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (obs !== O_PR) begin
            miscompares++;
            $display("FAIL alloc_before_reset: got %b, expected %b", obs, O_PR);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 13'h0000) begin
            miscompares++;
            $display("FAIL alloc_async_reset: got %b, expected %b", obs, 13'h0000);
        end
        l2_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        got_q.delete(); exp_q.delete();
        run_txn(1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1, 1);
        foreach (got_q[i]) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL after_reset[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

`ifdef L2_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        #2 rst = 1'b0;
        exp_hits = 0; exp_misses = 0;
        got_q.delete(); exp_q.delete();
        for (int t = 0; t < 3; t++) run_txn(1'b1, rb(), (t % 2) + 1, rb(), 1'b0, 1'b0, 1, 1);
        run_txn(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 2);
        idle(1);
        vectors++;
        if (hit_count !== 3'(exp_hits) || exp_hits != 3) begin
            miscompares++;
            $display("FAIL perf_hits: hit_count %0d, expected 3", hit_count);
        end
        vectors++;
        if (miss_count !== 3'(exp_misses) || exp_misses != 1) begin
            miscompares++;
            $display("FAIL perf_misses: miss_count %0d, expected 1", miss_count);
        end
        for (int t = 0; t < 8; t++) run_txn(1'b1, 1'b0, 0, rb(), 1'b0, 1'b0, 1, 1);
        idle(1);
        vectors++;
        if (miss_count !== 3'(CNT_MAX)) begin
            miscompares++;
            $display("FAIL perf_saturate: miss_count %0d, expected %0d", miss_count, CNT_MAX);
        end
        foreach (got_q[i]) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL perf_trace[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_clean_miss();
        test_dirty_miss();
        test_dropped();
        test_back_to_back();
        test_random();
        test_reset_in_allocate();
`ifdef L2_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
